bp_fe_bht_updater: RTL and testbench

BP_FE_BHT_UPDATER -- requirements
Module: bp_fe_bht_updater

---
 rtl/bp_fe_bht_updater.sv | 113 +++++++++++
 tb/tb_bp_fe_bht_updater.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_updater.sv
// Records in-flight BHT predictions in a small FIFO and, when the oldest branch
// resolves, issues a registered BHT write carrying the index, direction and correctness.
module bp_fe_bht_updater #(
  parameter bht_idx_width_p = "inv",
  parameter fifo_els_p      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,

  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,

  input  logic                       flush_i,

  output logic                       bht_w_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_w_o,
  output logic                       bht_correct_o,
  output logic                       bht_pred_taken_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);

  logic [bht_idx_width_p:0] mem_q [fifo_els_p];

  logic [ptr_w_lp-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]        rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] w_idx_q, w_idx_d;
  logic                       correct_q, correct_d;
  logic                       pred_taken_q, pred_taken_d;

  logic                       full, empty, push, pop;
  logic [bht_idx_width_p:0]   head;

  always_comb begin
    full  = (cnt_q == full_cnt_lp);
    empty = (cnt_q == '0);
    push  = pred_v_i & ~full;
    pop   = res_v_i & ~empty;
    head  = mem_q[rd_ptr_q];

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    w_v_d        = 1'b0;
    w_idx_d      = w_idx_q;
    correct_d    = correct_q;
    pred_taken_d = pred_taken_q;

    // Flush drops a same-cycle push and pop, so no write is generated for it.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + ptr_w_lp'(1);
        w_v_d        = 1'b1;
        w_idx_d      = head[bht_idx_width_p:1];
        pred_taken_d = head[0];
        correct_d    = (head[0] == res_taken_i);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
        2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      w_v_q        <= 1'b0;
      w_idx_q      <= '0;
      correct_q    <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      w_v_q        <= w_v_d;
      w_idx_q      <= w_idx_d;
      correct_q    <= correct_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push & ~flush_i & ~reset_i) mem_q[wr_ptr_q] <= {pred_idx_i, pred_taken_i};
  end

  assign pred_ready_o     = ~full;
  assign res_ready_o      = ~empty;
  assign bht_w_v_o        = w_v_q;
  assign bht_idx_w_o      = w_idx_q;
  assign bht_correct_o    = correct_q;
  assign bht_pred_taken_o = pred_taken_q;

endmodule

// File: tb/tb_bp_fe_bht_updater.sv
// Directed vector bench for bp_fe_bht_updater with 4-bit index and a 4-deep FIFO.
module tb_bp_fe_bht_updater;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_v, pred_taken, pred_ready;
  logic [IW-1:0] pred_idx;
  logic          res_v, res_taken, res_ready;
  logic          flush;
  logic          w_v, correct, pt;
  logic [IW-1:0] w_idx;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  bp_fe_bht_updater #(.bht_idx_width_p(IW), .fifo_els_p(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .pred_v_i        (pred_v),
    .pred_idx_i      (pred_idx),
    .pred_taken_i    (pred_taken),
    .pred_ready_o    (pred_ready),
    .res_v_i         (res_v),
    .res_taken_i     (res_taken),
    .res_ready_o     (res_ready),
    .flush_i         (flush),
    .bht_w_v_o       (w_v),
    .bht_idx_w_o     (w_idx),
    .bht_correct_o   (correct),
    .bht_pred_taken_o(pt)
  );

  typedef struct {
    logic          pv;
    logic [IW-1:0] idx;
    logic          tk;
    logic          rv;
    logic          rt;
    logic          fl;
    logic          rs;
    logic          e_pr;
    logic          e_rr;
    logic          e_wv;
    logic [IW-1:0] e_idx;
    logic          e_c;
    logic          e_pt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int step, input logic [IW-1:0] act,
                     input logic [IW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [IW-1:0] idx, input logic tk,
                       input logic rv, input logic rt, input logic fl, input logic rs);
    pred_v = pv; pred_idx = idx; pred_taken = tk;
    res_v = rv; res_taken = rt; flush = fl; reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int step, input logic e_pr, input logic e_rr, input logic e_wv,
                           input logic [IW-1:0] e_idx, input logic e_c, input logic e_pt);
    chk("pred_ready", step, IW'(pred_ready), IW'(e_pr));
    chk("res_ready",  step, IW'(res_ready),  IW'(e_rr));
    chk("w_v",        step, IW'(w_v),        IW'(e_wv));
    chk("w_idx",      step, w_idx,           e_idx);
    chk("correct",    step, IW'(correct),    IW'(e_c));
    chk("pred_taken", step, IW'(pt),         IW'(e_pt));
  endtask

  initial begin
    pred_v = 0; pred_idx = 0; pred_taken = 0;
    res_v = 0; res_taken = 0; flush = 0; reset = 1;

    //             pv idx tk rv rt fl rs   pr rr wv idx c pt
    vq.push_back('{0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0});  // reset state
    // single push then resolve
    vq.push_back('{1, 5, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 1, 0, 0,   1, 0, 1, 5, 1, 1});
    vq.push_back('{0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 5, 1, 1});
    // mispredict ordering
    vq.push_back('{1, 1, 1, 0, 0, 0, 0,   1, 1, 0, 5, 1, 1});
    vq.push_back('{1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 5, 1, 1});
    vq.push_back('{1, 3, 1, 0, 0, 0, 0,   1, 1, 0, 5, 1, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 1, 0, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 2, 1, 0});
    vq.push_back('{0, 0, 0, 1, 1, 0, 0,   1, 0, 1, 3, 1, 1});
    vq.push_back('{0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 3, 1, 1});
    // fill to full, push ignored when full, interleaved push/pop wraps pointers
    vq.push_back('{1, 6, 0, 0, 0, 0, 0,   1, 1, 0, 3, 1, 1});
    vq.push_back('{1, 7, 1, 0, 0, 0, 0,   1, 1, 0, 3, 1, 1});
    vq.push_back('{1, 8, 0, 0, 0, 0, 0,   1, 1, 0, 3, 1, 1});
    vq.push_back('{1, 9, 1, 0, 0, 0, 0,   0, 1, 0, 3, 1, 1});
    vq.push_back('{1,10, 1, 0, 0, 0, 0,   0, 1, 0, 3, 1, 1});
    vq.push_back('{1,10, 1, 1, 0, 0, 0,   1, 1, 1, 6, 1, 0});
    vq.push_back('{1,10, 1, 1, 0, 0, 0,   1, 1, 1, 7, 0, 1});
    vq.push_back('{1,11, 0, 1, 0, 0, 0,   1, 1, 1, 8, 1, 0});
    vq.push_back('{0, 0, 0, 1, 1, 0, 0,   1, 1, 1, 9, 1, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 1, 1,10, 0, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 0, 1,11, 1, 0});
    vq.push_back('{0, 0, 0, 1, 1, 0, 0,   1, 0, 0,11, 1, 0});
    // push and resolve together on empty: only the push takes effect
    vq.push_back('{1,12, 1, 1, 1, 0, 0,   1, 1, 0,11, 1, 0});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 0, 1,12, 0, 1});
    // flush with a pending write from the prior cycle
    vq.push_back('{1,13, 0, 0, 0, 0, 0,   1, 1, 0,12, 0, 1});
    vq.push_back('{1,14, 1, 0, 0, 0, 0,   1, 1, 0,12, 0, 1});
    vq.push_back('{1,15, 0, 0, 0, 0, 0,   1, 1, 0,12, 0, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 1, 1,13, 1, 0});
    vq.push_back('{0, 0, 0, 1, 1, 1, 0,   1, 0, 0,13, 1, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 0,   1, 0, 0,13, 1, 0});
    // reset mid-operation with a pop in the reset cycle
    vq.push_back('{1, 1, 1, 0, 0, 0, 0,   1, 1, 0,13, 1, 0});
    vq.push_back('{1, 2, 0, 0, 0, 0, 0,   1, 1, 0,13, 1, 0});
    vq.push_back('{0, 0, 0, 1, 1, 0, 0,   1, 1, 1, 1, 1, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0});
    vq.push_back('{1, 3, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 1, 0, 0,   1, 0, 1, 3, 1, 1});
    // flush beats a same-cycle push
    vq.push_back('{1, 4, 0, 0, 0, 1, 0,   1, 0, 0, 3, 1, 1});
    vq.push_back('{0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 3, 1, 1});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].pv, vq[i].idx, vq[i].tk, vq[i].rv, vq[i].rt, vq[i].fl, vq[i].rs);
      check_all(i, vq[i].e_pr, vq[i].e_rr, vq[i].e_wv, vq[i].e_idx, vq[i].e_c, vq[i].e_pt);
    end

    // index width extremes; write visible in the flush cycle, gone after it
    drive(1, 4'hF, 1, 0, 0, 0, 0);
    drive(1, 4'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_all(100, 1, 1, 1, 4'hF, 0, 1);
    drive(0, 0, 0, 1, 1, 1, 0);
    check_all(101, 1, 0, 0, 4'hF, 0, 1);
    drive(1, 4'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_all(102, 1, 0, 1, 4'h0, 1, 0);

    // same-cycle push/resolve on empty: res_ready low before the edge
    pred_v = 1; pred_idx = 4'h9; pred_taken = 0; res_v = 1; res_taken = 0;
    #1;
    chk("res_ready_pre", 103, IW'(res_ready), IW'(1'b0));
    @(posedge clk);
    #1;
    chk("w_v_post", 104, IW'(w_v), IW'(1'b0));
    chk("res_ready_post", 104, IW'(res_ready), IW'(1'b1));
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
